// File: rtl/spike_axi_pkg.sv
// Shared definitions for the spike AXI memory slave: response codes, legal
// size/burst encodings, engine state enums and the burst address stepper.
package spike_axi_pkg;

  localparam logic       RESP_OKAY   = 1'b0;
  localparam logic       RESP_SLVERR = 1'b1;

  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DLY, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DLY, R_DATA}         rd_state_t;

  // Address of the next beat. The caller truncates the result to its address
  // width, which gives the wrap modulo the memory size for INCR bursts.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst);
    return (burst == BURST_INCR) ? addr + 32'd4 : addr;
  endfunction

endpackage

// File: rtl/spike_axi_mem_ram.sv
// Word-organised RAM: one byte-enable write port, one registered read port.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   wr_en_i           write enable
//   wr_addr_i         word address of the write
//   wr_data_i         write data
//   wr_strb_i         byte enables, bit b writes byte lane b
//   rd_en_i           load the read register this cycle
//   rd_addr_i         word address of the read
//   rd_data_o         registered read data
module spike_axi_mem_ram #(
  parameter int unsigned WORD_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [WORD_AW-1:0] wr_addr_i,
  input  logic [31:0]        wr_data_i,
  input  logic [3:0]         wr_strb_i,
  input  logic               rd_en_i,
  input  logic [WORD_AW-1:0] rd_addr_i,
  output logic [31:0]        rd_data_o
);

  logic [31:0] mem_q [2**WORD_AW];
  logic [31:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto a RAM macro; contents
  // survive a bus reset, only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // NOTE: non-blocking on both the array write and this read means a
  // same-cycle write and read of one word returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spike_axi_mem_slave.sv
// AXI slave memory answering the CPUNC_* initiator. Independent write and
// read engines, INCR/FIXED bursts, byte strobes, optional response delay.
// Ports: CPUNC_ACLK/CPUNC_ARESETn clock and async active-low reset;
//   AW*/W*/B* write address, data and response channels;
//   AR*/R* read address and data channels. LOCK/CACHE/PROT/QOS and WID
//   are accepted and ignored.
module spike_axi_mem_slave
  import spike_axi_pkg::*;
#(
  parameter int unsigned MEM_POWER_SIZE = 12,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = MEM_POWER_SIZE,
  parameter int unsigned AXI_MASK_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int unsigned RESP_DELAY     = 0
) (
  input  logic                      CPUNC_ACLK,
  input  logic                      CPUNC_ARESETn,
  input  logic [7:0]                CPUNC_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
  input  logic [7:0]                CPUNC_AWLN,
  input  logic [1:0]                CPUNC_AWSIZE,
  input  logic [1:0]                CPUNC_AWBURST,
  input  logic                      CPUNC_AWLOCK,
  input  logic [2:0]                CPUNC_AWCACHE,
  input  logic                      CPUNC_AWPROT,
  input  logic [2:0]                CPUNC_AWQOS,
  input  logic                      CPUNC_AWVALID,
  output logic                      CPUNC_AWREADY,
  input  logic [7:0]                CPUNC_WID,
  input  logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
  input  logic [AXI_MASK_WIDTH-1:0] CPUNC_WSTRB,
  input  logic                      CPUNC_WLAST,
  input  logic                      CPUNC_WVALID,
  output logic                      CPUNC_WREADY,
  output logic [7:0]                CPUNC_BID,
  output logic                      CPUNC_BRESP,
  output logic                      CPUNC_BVALID,
  input  logic                      CPUNC_BREADY,
  input  logic [7:0]                CPUNC_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
  input  logic [7:0]                CPUNC_ARLN,
  input  logic [1:0]                CPUNC_ARSIZE,
  input  logic [1:0]                CPUNC_ARBURST,
  input  logic                      CPUNC_ARLOCK,
  input  logic [2:0]                CPUNC_ARCACHE,
  input  logic                      CPUNC_ARPROT,
  input  logic [2:0]                CPUNC_ARQOS,
  input  logic                      CPUNC_ARVALID,
  output logic                      CPUNC_ARREADY,
  output logic [7:0]                CPUNC_RID,
  output logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
  output logic                      CPUNC_RRESP,
  output logic                      CPUNC_RLAST,
  output logic                      CPUNC_RVALID,
  input  logic                      CPUNC_RREADY
);

  localparam int unsigned WORD_AW  = MEM_POWER_SIZE - 2;
  // Final count of the delay counter; unreachable when RESP_DELAY is 0.
  localparam logic [3:0]  DLY_LAST = 4'(RESP_DELAY - 1);

  logic clk, rst_n;
  assign clk   = CPUNC_ACLK;
  assign rst_n = CPUNC_ARESETn;

  // ---------------- write engine ----------------
  wr_state_t                 wr_state_q;
  logic                      awready_q, wready_q, bvalid_q, wr_err_q;
  logic [7:0]                wr_id_q, wr_len_q, wr_cnt_q;
  logic [1:0]                wr_burst_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
  logic [3:0]                wr_dly_q;
  logic [31:0]               wr_next_addr;
  logic                      aw_hs, w_hs, w_last_beat;

  assign aw_hs        = CPUNC_AWVALID && awready_q;
  assign w_hs         = CPUNC_WVALID && wready_q;
  assign w_last_beat  = (wr_cnt_q == wr_len_q);
  assign wr_next_addr = next_addr(32'(wr_addr_q), wr_burst_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_id_q    <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_burst_q <= '0;
      wr_addr_q  <= '0;
      wr_dly_q   <= '0;
    end else begin
      unique case (wr_state_q)
        W_IDLE: if (aw_hs) begin
          wr_id_q    <= CPUNC_AWID;
          wr_addr_q  <= CPUNC_AWADDR;
          wr_len_q   <= CPUNC_AWLN;
          wr_burst_q <= CPUNC_AWBURST;
          wr_err_q   <= (CPUNC_AWSIZE != SIZE_WORD) ||
                        ((CPUNC_AWBURST != BURST_FIXED) && (CPUNC_AWBURST != BURST_INCR));
          wr_cnt_q   <= '0;
          awready_q  <= 1'b0;
          wready_q   <= 1'b1;
          wr_state_q <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          // WLAST is checked but never used to end the burst early.
          if (CPUNC_WLAST != w_last_beat) wr_err_q <= 1'b1;
          if (w_last_beat) begin
            wready_q <= 1'b0;
            if (RESP_DELAY == 0) begin
              bvalid_q   <= 1'b1;
              wr_state_q <= W_RESP;
            end else begin
              wr_dly_q   <= '0;
              wr_state_q <= W_DLY;
            end
          end else begin
            wr_cnt_q  <= wr_cnt_q + 8'd1;
            wr_addr_q <= wr_next_addr[AXI_ADDR_WIDTH-1:0];
          end
        end
        W_DLY: begin
          if (wr_dly_q == DLY_LAST) begin
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end else begin
            wr_dly_q <= wr_dly_q + 4'd1;
          end
        end
        W_RESP: if (CPUNC_BREADY) begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign CPUNC_AWREADY = awready_q;
  assign CPUNC_WREADY  = wready_q;
  assign CPUNC_BVALID  = bvalid_q;
  assign CPUNC_BID     = wr_id_q;
  assign CPUNC_BRESP   = wr_err_q ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read engine ----------------
  rd_state_t                 rd_state_q;
  logic                      arready_q, rvalid_q, rd_err_q;
  logic [7:0]                rd_id_q, rd_len_q, rd_cnt_q;
  logic [1:0]                rd_burst_q;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
  logic [3:0]                rd_dly_q;
  logic [31:0]               rd_next_addr;
  logic                      ar_hs, r_hs, r_last_beat;
  logic                      ram_rd_en;
  logic [WORD_AW-1:0]        ram_rd_addr;
  logic [31:0]               ram_rd_data;

  assign ar_hs        = CPUNC_ARVALID && arready_q;
  assign r_hs         = rvalid_q && CPUNC_RREADY;
  assign r_last_beat  = (rd_cnt_q == rd_len_q);
  assign rd_next_addr = next_addr(32'(rd_addr_q), rd_burst_q);

  // The RAM read is issued on the same edge that raises RVALID, or that
  // retires a beat, so the data register always holds the presented beat.
  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = rd_addr_q[MEM_POWER_SIZE-1:2];
    if ((RESP_DELAY == 0) && (rd_state_q == R_IDLE) && ar_hs) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = CPUNC_ARADDR[MEM_POWER_SIZE-1:2];
    end else if ((rd_state_q == R_DLY) && (rd_dly_q == DLY_LAST)) begin
      ram_rd_en = 1'b1;
    end else if ((rd_state_q == R_DATA) && r_hs && !r_last_beat) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = rd_next_addr[MEM_POWER_SIZE-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_id_q    <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_burst_q <= '0;
      rd_addr_q  <= '0;
      rd_dly_q   <= '0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: if (ar_hs) begin
          rd_id_q    <= CPUNC_ARID;
          rd_addr_q  <= CPUNC_ARADDR;
          rd_len_q   <= CPUNC_ARLN;
          rd_burst_q <= CPUNC_ARBURST;
          rd_err_q   <= (CPUNC_ARSIZE != SIZE_WORD) ||
                        ((CPUNC_ARBURST != BURST_FIXED) && (CPUNC_ARBURST != BURST_INCR));
          rd_cnt_q   <= '0;
          arready_q  <= 1'b0;
          if (RESP_DELAY == 0) begin
            rvalid_q   <= 1'b1;
            rd_state_q <= R_DATA;
          end else begin
            rd_dly_q   <= '0;
            rd_state_q <= R_DLY;
          end
        end
        R_DLY: begin
          if (rd_dly_q == DLY_LAST) begin
            rvalid_q   <= 1'b1;
            rd_state_q <= R_DATA;
          end else begin
            rd_dly_q <= rd_dly_q + 4'd1;
          end
        end
        R_DATA: if (r_hs) begin
          if (r_last_beat) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end else begin
            rd_cnt_q  <= rd_cnt_q + 8'd1;
            rd_addr_q <= rd_next_addr[AXI_ADDR_WIDTH-1:0];
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign CPUNC_ARREADY = arready_q;
  assign CPUNC_RVALID  = rvalid_q;
  assign CPUNC_RID     = rd_id_q;
  assign CPUNC_RRESP   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
  assign CPUNC_RLAST   = rvalid_q && r_last_beat;
  // Error bursts still walk the RAM but never expose its contents.
  assign CPUNC_RDATA   = rd_err_q ? '0 : ram_rd_data;

  spike_axi_mem_ram #(.WORD_AW(WORD_AW)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_hs && !wr_err_q),
    .wr_addr_i (wr_addr_q[MEM_POWER_SIZE-1:2]),
    .wr_data_i (CPUNC_WDATA),
    .wr_strb_i (CPUNC_WSTRB),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  logic unused_ok;
  assign unused_ok = ^{CPUNC_AWLOCK, CPUNC_AWCACHE, CPUNC_AWPROT, CPUNC_AWQOS,
                       CPUNC_ARLOCK, CPUNC_ARCACHE, CPUNC_ARPROT, CPUNC_ARQOS,
                       CPUNC_WID, wr_next_addr[31:AXI_ADDR_WIDTH],
                       rd_next_addr[31:AXI_ADDR_WIDTH]};

endmodule

// File: tb/tb_spike_axi_mem_slave.sv
// Scoreboard bench: two slaves (RESP_DELAY 0 and 3) share one stimulus bus
// selected by sel3; tasks push expected B/R responses, a monitor pops them.
module tb_spike_axi_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel3 = 1'b0;
  logic [7:0]  awid = '0, awln = '0, arid = '0, arln = '0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [1:0]  awsize = 2'b10, awburst = 2'b01, arsize = 2'b10, arburst = 2'b01;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        d0_awready, d0_wready, d0_bvalid, d0_bresp, d0_arready, d0_rvalid, d0_rresp, d0_rlast;
  logic        d3_awready, d3_wready, d3_bvalid, d3_bresp, d3_arready, d3_rvalid, d3_rresp, d3_rlast;
  logic [7:0]  d0_bid, d0_rid, d3_bid, d3_rid;
  logic [31:0] d0_rdata, d3_rdata;

  logic        awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast;
  logic [7:0]  bid, rid;
  logic [31:0] rdata;

  assign awready = sel3 ? d3_awready : d0_awready;
  assign wready  = sel3 ? d3_wready  : d0_wready;
  assign bvalid  = sel3 ? d3_bvalid  : d0_bvalid;
  assign bresp   = sel3 ? d3_bresp   : d0_bresp;
  assign bid     = sel3 ? d3_bid     : d0_bid;
  assign arready = sel3 ? d3_arready : d0_arready;
  assign rvalid  = sel3 ? d3_rvalid  : d0_rvalid;
  assign rresp   = sel3 ? d3_rresp   : d0_rresp;
  assign rlast   = sel3 ? d3_rlast   : d0_rlast;
  assign rid     = sel3 ? d3_rid     : d0_rid;
  assign rdata   = sel3 ? d3_rdata   : d0_rdata;

  always #5 clk = ~clk;

  spike_axi_mem_slave #(.RESP_DELAY(0)) u_dut0 (
    .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst_n),
    .CPUNC_AWID(awid), .CPUNC_AWADDR(awaddr), .CPUNC_AWLN(awln), .CPUNC_AWSIZE(awsize),
    .CPUNC_AWBURST(awburst), .CPUNC_AWLOCK(1'b0), .CPUNC_AWCACHE(3'b0), .CPUNC_AWPROT(1'b0),
    .CPUNC_AWQOS(3'b0), .CPUNC_AWVALID(awvalid & ~sel3), .CPUNC_AWREADY(d0_awready),
    .CPUNC_WID(8'h0), .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast),
    .CPUNC_WVALID(wvalid & ~sel3), .CPUNC_WREADY(d0_wready),
    .CPUNC_BID(d0_bid), .CPUNC_BRESP(d0_bresp), .CPUNC_BVALID(d0_bvalid), .CPUNC_BREADY(bready & ~sel3),
    .CPUNC_ARID(arid), .CPUNC_ARADDR(araddr), .CPUNC_ARLN(arln), .CPUNC_ARSIZE(arsize),
    .CPUNC_ARBURST(arburst), .CPUNC_ARLOCK(1'b0), .CPUNC_ARCACHE(3'b0), .CPUNC_ARPROT(1'b0),
    .CPUNC_ARQOS(3'b0), .CPUNC_ARVALID(arvalid & ~sel3), .CPUNC_ARREADY(d0_arready),
    .CPUNC_RID(d0_rid), .CPUNC_RDATA(d0_rdata), .CPUNC_RRESP(d0_rresp), .CPUNC_RLAST(d0_rlast),
    .CPUNC_RVALID(d0_rvalid), .CPUNC_RREADY(rready & ~sel3)
  );

  spike_axi_mem_slave #(.RESP_DELAY(3)) u_dut3 (
    .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst_n),
    .CPUNC_AWID(awid), .CPUNC_AWADDR(awaddr), .CPUNC_AWLN(awln), .CPUNC_AWSIZE(awsize),
    .CPUNC_AWBURST(awburst), .CPUNC_AWLOCK(1'b0), .CPUNC_AWCACHE(3'b0), .CPUNC_AWPROT(1'b0),
    .CPUNC_AWQOS(3'b0), .CPUNC_AWVALID(awvalid & sel3), .CPUNC_AWREADY(d3_awready),
    .CPUNC_WID(8'h0), .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast),
    .CPUNC_WVALID(wvalid & sel3), .CPUNC_WREADY(d3_wready),
    .CPUNC_BID(d3_bid), .CPUNC_BRESP(d3_bresp), .CPUNC_BVALID(d3_bvalid), .CPUNC_BREADY(bready & sel3),
    .CPUNC_ARID(arid), .CPUNC_ARADDR(araddr), .CPUNC_ARLN(arln), .CPUNC_ARSIZE(arsize),
    .CPUNC_ARBURST(arburst), .CPUNC_ARLOCK(1'b0), .CPUNC_ARCACHE(3'b0), .CPUNC_ARPROT(1'b0),
    .CPUNC_ARQOS(3'b0), .CPUNC_ARVALID(arvalid & sel3), .CPUNC_ARREADY(d3_arready),
    .CPUNC_RID(d3_rid), .CPUNC_RDATA(d3_rdata), .CPUNC_RRESP(d3_rresp), .CPUNC_RLAST(d3_rlast),
    .CPUNC_RVALID(d3_rvalid), .CPUNC_RREADY(rready & sel3)
  );

  typedef struct packed {logic [7:0] id; logic resp;} b_exp_t;
  typedef struct packed {logic [7:0] id; logic [31:0] data; logic resp; logic last;} r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] wbuf [8];
  logic [3:0]  sbuf [8];
  logic [31:0] ebuf [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every B and R handshake against the queued expectation.
  initial begin : monitor
    b_exp_t be;
    r_exp_t re;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bvalid && bready) begin
        check("b_expected", 64'(b_q.size() != 0), 1);
        if (b_q.size() != 0) begin
          be = b_q.pop_front();
          check("b_id", bid, be.id);
          check("b_resp", bresp, be.resp);
        end
      end
      if (rst_n && rvalid && rready) begin
        check("r_expected", 64'(r_q.size() != 0), 1);
        if (r_q.size() != 0) begin
          re = r_q.pop_front();
          check("r_id", rid, re.id);
          check("r_data", rdata, re.data);
          check("r_resp", rresp, re.resp);
          check("r_last", rlast, re.last);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [1:0] size, input logic [1:0] burst, input int last_at,
                          input logic exp_resp, input int bstall, output int lat);
    int n;
    b_q.push_back(b_exp_t'{id: id, resp: exp_resp});
    awid = id; awaddr = addr; awln = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check("aw_accept", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      check("w_accept", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    lat = 1;
    while (!bvalid && lat < 100) begin @(negedge clk); lat++; end
    for (int i = 0; i < bstall; i++) begin
      check("b_hold_valid", bvalid, 1);
      check("b_hold_id", bid, id);
      check("b_hold_resp", bresp, exp_resp);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic exp_resp, input logic [3:0] pat,
                         output int lat);
    int n, got, cyc;
    logic [31:0] ed;
    for (int i = 0; i <= int'(len); i++)
      r_q.push_back(r_exp_t'{id: id, data: exp_resp ? 32'h0 : ebuf[i], resp: exp_resp,
                             last: (i == int'(len))});
    arid = id; araddr = addr; arln = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("ar_accept", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 100) begin @(negedge clk); lat++; end
    got = 0; cyc = 0;
    while (got <= int'(len) && cyc < 200) begin
      rready = pat[3 - (cyc % 4)];
      if (rvalid && rready) got++;
      else if (rvalid) begin
        ed = exp_resp ? 32'h0 : ebuf[got];
        check("r_hold_data", rdata, ed);
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", got, len + 1);
  endtask

  initial begin : stim
    int lat;
    repeat (3) @(negedge clk);
    // Reset values, sampled while reset is still asserted.
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ids", {bid, rid}, 0);
    check("rst_resp_last", {bresp, rresp, rlast}, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word write/read, zero-delay latency.
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(8'd5, 12'h010, 8'd0, 2'b10, 2'b01, 0, 1'b0, 0, lat);
    check("t1_b_latency", lat, 1);
    ebuf[0] = 32'hDEADBEEF;
    do_read(8'd7, 12'h010, 8'd0, 2'b01, 1'b0, 4'b1111, lat);
    check("t1_r_latency", lat, 1);

    // 2: byte strobe merge.
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(8'd1, 12'h020, 8'd0, 2'b10, 2'b01, 0, 1'b0, 0, lat);
    wbuf[0] = 32'h000000AB; sbuf[0] = 4'h1;
    do_write(8'd2, 12'h020, 8'd0, 2'b10, 2'b01, 0, 1'b0, 0, lat);
    ebuf[0] = 32'h112233AB;
    do_read(8'd2, 12'h020, 8'd0, 2'b01, 1'b0, 4'b1111, lat);

    // 3: INCR burst wrapping past the top of memory, stalled read.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; ebuf[i] = 32'(i + 1); end
    do_write(8'd3, 12'hFF8, 8'd3, 2'b10, 2'b01, 3, 1'b0, 0, lat);
    do_read(8'd4, 12'hFF8, 8'd3, 2'b01, 1'b0, 4'b1010, lat);
    ebuf[0] = 32'd3;
    do_read(8'd8, 12'h000, 8'd0, 2'b01, 1'b0, 4'b1111, lat);
    // FIXED burst keeps the address: last beat wins, reads repeat it.
    wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(8'd9, 12'h040, 8'd1, 2'b10, 2'b00, 1, 1'b0, 0, lat);
    ebuf[0] = 32'hB1B1B1B1; ebuf[1] = 32'hB1B1B1B1;
    do_read(8'd9, 12'h040, 8'd1, 2'b00, 1'b0, 4'b1111, lat);

    // 4: error responses.
    wbuf[0] = 32'hCAFEF00D; sbuf[0] = 4'hF;
    do_write(8'h10, 12'h030, 8'd0, 2'b10, 2'b01, 0, 1'b0, 0, lat);
    wbuf[0] = 32'h12345678;
    do_write(8'h11, 12'h030, 8'd0, 2'b01, 2'b01, 0, 1'b1, 0, lat);
    ebuf[0] = 32'hCAFEF00D;
    do_read(8'h12, 12'h030, 8'd0, 2'b01, 1'b0, 4'b1111, lat);
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    do_write(8'h13, 12'h050, 8'd1, 2'b10, 2'b01, 0, 1'b1, 0, lat);
    do_write(8'h14, 12'h058, 8'd1, 2'b10, 2'b01, 99, 1'b1, 0, lat);
    do_read(8'h15, 12'h060, 8'd2, 2'b10, 1'b1, 4'b1111, lat);
    do_write(8'h16, 12'h064, 8'd0, 2'b10, 2'b11, 0, 1'b1, 0, lat);

    // 5: response delay of 3 on the second slave, BREADY held low.
    sel3 = 1'b1;
    @(negedge clk);
    wbuf[0] = 32'h55AA55AA; sbuf[0] = 4'hF;
    do_write(8'h21, 12'h060, 8'd0, 2'b10, 2'b01, 0, 1'b0, 5, lat);
    check("t5_b_latency", lat, 4);
    ebuf[0] = 32'h55AA55AA;
    do_read(8'h22, 12'h060, 8'd0, 2'b01, 1'b0, 4'b1111, lat);
    check("t5_r_latency", lat, 4);
    sel3 = 1'b0;
    @(negedge clk);
    wbuf[0] = 32'h0BADF00D;
    do_write(8'h23, 12'h068, 8'd0, 2'b10, 2'b01, 0, 1'b0, 5, lat);
    check("t5_b_latency_d0", lat, 1);

    // 6: reset in the middle of a 4-beat write; no B may appear.
    awid = 8'h0E; awaddr = 12'h070; awln = 8'd3; awsize = 2'b10; awburst = 2'b01; awvalid = 1'b1;
    for (int n = 0; n < 100 && !awready; n++) @(negedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'(i); wstrb = 4'hF; wvalid = 1'b1;
      for (int n = 0; n < 100 && !wready; n++) @(negedge clk);
      @(negedge clk);
    end
    wdata = 32'h2; wvalid = 1'b1;
    check("t6_mid_burst_wready", wready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bvalid", bvalid, 0);
    check("t6_rst_rvalid", rvalid, 0);
    check("t6_rst_awready", awready, 1);
    check("t6_rst_arready", arready, 1);
    check("t6_rst_wready", wready, 0);
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wbuf[0] = 32'h600DCAFE; sbuf[0] = 4'hF;
    do_write(8'h31, 12'h080, 8'd0, 2'b10, 2'b01, 0, 1'b0, 0, lat);
    ebuf[0] = 32'h600DCAFE;
    do_read(8'h32, 12'h080, 8'd0, 2'b01, 1'b0, 4'b1111, lat);

    repeat (3) @(negedge clk);
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
